// File: rtl/top_serial_queue.sv
// Serial-to-parallel receiver: MSB-first bit deserializer feeding a DEPTH-entry word FIFO.
// Optional TOP_MANUAL_ENQUEUE_EN holds each completed word until an enqueue_in rising edge.
module top_serial_queue #(
    parameter int WORD_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic              clock_1MHz,
    input  logic              rst,
    input  logic              data_in,
    input  logic              write_in,
    input  logic              enqueue_in,
    input  logic              dequeue_in,
    output logic              status_out,
    output logic [WORD_W-1:0] data_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(WORD_W + 1);
    localparam logic [PTR_W:0]   OCC_FULL  = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_WORD  = CNT_W'(WORD_W);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [PTR_W:0]    occ_q, occ_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              status_q, status_d;
    logic              wr_prev_q, dq_prev_q;

    logic wr_rise, dq_rise, word_ready, full, accept, push, pop;

    assign wr_rise    = write_in & ~wr_prev_q;
    assign dq_rise    = dequeue_in & ~dq_prev_q;
    assign word_ready = (cnt_q == CNT_WORD);
    assign full       = (occ_q == OCC_FULL);
    // A completed word must leave the shift register before another bit may land.
    assign accept     = wr_rise & status_q & ~word_ready;
    assign pop        = dq_rise & (occ_q != '0);

`ifdef TOP_MANUAL_ENQUEUE_EN
    logic enq_prev_q;
    logic enq_rise;
    assign enq_rise = enqueue_in & ~enq_prev_q;
    assign push     = word_ready & enq_rise & ~full;

    always_ff @(posedge clock_1MHz) begin
        if (rst) enq_prev_q <= 1'b0;
        else     enq_prev_q <= enqueue_in;
    end
`else
    logic unused_enqueue;
    assign unused_enqueue = enqueue_in;
    assign push           = word_ready & ~full;
`endif

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        head_d  = head_q;
        tail_d  = tail_q;
        occ_d   = occ_q;
        data_d  = data_q;

        if (accept) begin
            shift_d = {shift_q[WORD_W-2:0], data_in};
            cnt_d   = cnt_q + 1'b1;
        end
        if (push) begin
            cnt_d  = '0;
            tail_d = tail_q + 1'b1;
        end
        if (pop) begin
            data_d = mem_q[head_q];
            head_d = head_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase

`ifdef TOP_MANUAL_ENQUEUE_EN
        status_d = (occ_q < OCC_FULL) && (cnt_d != CNT_WORD);
`else
        status_d = (occ_q < OCC_FULL);
`endif
    end

    always_ff @(posedge clock_1MHz) begin
        if (rst) begin
            shift_q   <= '0;
            cnt_q     <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            occ_q     <= '0;
            data_q    <= '0;
            status_q  <= 1'b0;
            wr_prev_q <= 1'b0;
            dq_prev_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            occ_q     <= occ_d;
            data_q    <= data_d;
            status_q  <= status_d;
            wr_prev_q <= write_in;
            dq_prev_q <= dequeue_in;
            if (push) mem_q[tail_q] <= shift_q;
        end
    end

    assign status_out = status_q;
    assign data_out   = data_q;

endmodule

// File: tb/tb_top_serial_queue.sv
// Directed + randomized bench for top_serial_queue against a queue-based reference model.
`timescale 1ns/1ps
module tb_top_serial_queue;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst, data_in, write_in, enqueue_in, dequeue_in;
    logic       status_out;
    logic [7:0] data_out;

    int checks   = 0;
    int failures = 0;

    // Reference model: queued words, partial word being assembled, last dequeued word.
    logic [7:0] mq [$];
    logic [7:0] part;
    int         pcnt;
    logic [7:0] last_out;

    top_serial_queue #(.WORD_W(8), .DEPTH(DEPTH)) dut (
        .clock_1MHz (clk),
        .rst        (rst),
        .data_in    (data_in),
        .write_in   (write_in),
        .enqueue_in (enqueue_in),
        .dequeue_in (dequeue_in),
        .status_out (status_out),
        .data_out   (data_out)
    );

    always #500 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        part     = '0;
        pcnt     = 0;
        last_out = '0;
    endtask

    task automatic send_bit(input logic b, input int hi, input int lo);
        data_in  = b;
        write_in = 1'b1;
        if (mq.size() < DEPTH) begin
            part = {part[6:0], b};
            pcnt++;
            if (pcnt == 8) begin
                mq.push_back(part);
                pcnt = 0;
            end
        end
        tick(hi);
        write_in = 1'b0;
        tick(lo);
    endtask

    task automatic send_word(input logic [7:0] w, input int hi, input int lo);
        for (int i = 7; i >= 0; i--) send_bit(w[i], hi, lo);
    endtask

    task automatic dequeue(input string tag, input int hi, input int lo);
        dequeue_in = 1'b1;
        if (mq.size() > 0) last_out = mq.pop_front();
        tick(hi);
        dequeue_in = 1'b0;
        tick(lo);
        check(tag, data_out, last_out);
        check({tag, "_status"}, {7'd0, status_out}, {7'd0, mq.size() < DEPTH});
    endtask

    initial begin
        logic [7:0] w;
        rst = 1'b1; data_in = 1'b0; write_in = 1'b0; enqueue_in = 1'b0; dequeue_in = 1'b0;
        model_reset();

        // Reset values and release
        tick(3);
        check("rst_status", {7'd0, status_out}, 8'h00);
        check("rst_data", data_out, 8'h00);
        rst = 1'b0;
        tick(1);
        check("rel_status", {7'd0, status_out}, 8'h01);

        // Single word 0x80, then fill with 0x81..0x87
        send_word(8'h80, 10, 10);
        check("single_status", {7'd0, status_out}, 8'h01);
        for (int k = 1; k < 8; k++) send_word(8'h80 + 8'(k), 10, 10);
        check("full_status", {7'd0, status_out}, 8'h00);

        // Bits offered while full are dropped
        for (int k = 0; k < 4; k++) send_bit(1'b1, 10, 10);
        check("full_ignored_status", {7'd0, status_out}, 8'h00);
        check("full_ignored_data", data_out, 8'h00);

        // Drain four with long pulses, then the rest with random widths
        for (int k = 0; k < 4; k++) dequeue($sformatf("drain%0d", k), 200, 600);
        for (int k = 4; k < 8; k++) dequeue($sformatf("drain%0d", k), $urandom_range(1, 6), $urandom_range(2, 6));

        // Dequeue from empty holds data_out
        dequeue("empty_deq", 5, 5);
        check("empty_hold", data_out, 8'h87);

        // Random interleave of 12 words with dequeues, crossing the pointer wrap
        for (int k = 0; k < 12; k++) begin
            w = 8'($urandom);
            send_word(w, $urandom_range(2, 5), $urandom_range(2, 5));
            if ($urandom_range(0, 2) != 0)
                dequeue($sformatf("wrap%0d", k), $urandom_range(1, 5), $urandom_range(2, 5));
        end
        while (mq.size() > 0) dequeue("wrap_drain", $urandom_range(1, 5), $urandom_range(2, 5));
        dequeue("wrap_empty", 3, 3);

        // Dequeue on the same clock as an auto-enqueue
        send_word(8'h5A, 3, 3);
        w = 8'($urandom);
        for (int i = 7; i >= 1; i--) send_bit(w[i], 3, 3);
        data_in  = w[0];
        write_in = 1'b1;
        part = {part[6:0], w[0]};
        pcnt = 0;
        tick(1);
        dequeue_in = 1'b1;
        last_out = mq.pop_front();
        mq.push_back(part);
        tick(3);
        write_in = 1'b0;
        dequeue_in = 1'b0;
        tick(3);
        check("simul_pop", data_out, 8'h5A);
        dequeue("simul_next", 3, 3);
        dequeue("simul_empty", 3, 3);

        // Reset mid-word with strobes held high across release
        send_word(8'h3C, 3, 3);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 3, 3);
        rst = 1'b1; write_in = 1'b1; dequeue_in = 1'b1;
        model_reset();
        tick(2);
        check("rst2_status", {7'd0, status_out}, 8'h00);
        check("rst2_data", data_out, 8'h00);
        rst = 1'b0;
        tick(3);
        write_in = 1'b0; dequeue_in = 1'b0;
        tick(2);
        check("rst2_hold_data", data_out, 8'h00);
        w = 8'($urandom);
        send_word(w, 2, 2);
        dequeue("post_rst_word", 2, 2);
        dequeue("post_rst_empty", 2, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/top_serial_queue.md
Name: top_serial_queue

Overview:
Top-level serial-to-parallel receive block. It deserializes bits strobed on `data_in`/`write_in` into 8-bit words, MSB first, and pushes each completed word into an 8-entry FIFO. On each dequeue strobe it presents the oldest word on `data_out`. `status_out` tells the upstream sender when bits are accepted.

Parameters:
WORD_W, 8, bits per serial word and width of `data_out`
DEPTH, 8, FIFO capacity in words (power of two)

Ports:
clock_1MHz  input  1  system clock, 1 MHz; all logic on its rising edge
rst  input  1  synchronous reset, active-high
data_in  input  1  serial data bit, sampled on the `write_in` rising edge
write_in  input  1  bit strobe; level may stay high for many cycles
enqueue_in  input  1  manual enqueue strobe; used only with the optional feature
dequeue_in  input  1  dequeue strobe; level may stay high for many cycles
status_out  output  1  1 = ready to accept serial bits
data_out  output  WORD_W  last dequeued word

Behaviour:
- One clock and a synchronous active-high reset: every register is cleared on a `clock_1MHz` edge while `rst`=1.
- Reset values:
  - `status_out`=0, `data_out`=0
  - shift register=0, bit count=0
  - FIFO head=0, tail=0, occupancy=0
  - edge-detect history flops=0
- Strobe detection:
  - `write_in` and `dequeue_in` are edge-detected internally, rise = current&~prev.
  - One action per 0→1 transition, however long the level is held.
  - A level already high when reset releases is not an edge.
- `status_out` is registered, equal to (occupancy<DEPTH) and not in reset. It rises on the first clock after `rst` deasserts and falls the cycle after the FIFO becomes full.
- Deserializer:
  - On a `write_in` rise while `status_out`=1: shift = {shift[WORD_W-2:0], data_in} and bit count increments.
  - A rise while `status_out`=0 is ignored; no shift, no count.
  - The first bit received ends up in bit 7 (MSB-first).
- Auto-enqueue:
  - When the count reaches WORD_W, the word is written at the tail on the next clock.
  - Tail increments, occupancy increments, bit count clears to 0.
  - Latency is 1 cycle after the 8th bit edge.
  - Space is guaranteed because bits are only accepted while not full.
- Dequeue:
  - On a `dequeue_in` rise with occupancy>0: `data_out` <= mem[head], head increments, occupancy decrements.
  - `data_out` is valid 1 cycle after the rise edge is detected.
  - When empty, the rise is ignored and `data_out` holds its value.
- Enqueue and dequeue in the same cycle: both happen and occupancy is unchanged.
- Head and tail are log2(DEPTH) bits and wrap modulo DEPTH.
- Occupancy is log2(DEPTH)+1 bits and never exceeds DEPTH or drops below 0.
- A partial word (count<8) persists across dequeues and is lost only on reset.
- Reset mid-word or mid-queue discards all contents.

Optional Feature:
TOP_MANUAL_ENQUEUE_EN.
- Defined:
  - A completed word is held in the shift register (status_out forced 0 while a word is pending).
  - It is pushed only on an `enqueue_in` rising edge, if the FIFO is not full.
  - Then the bit count clears and `status_out` recovers.
- Undefined (default):
  - `enqueue_in` is ignored entirely, so an undriven or X input is harmless.
  - Words auto-enqueue as described above.

Test Plan:
- Reset: hold `rst`=1 for 3 cycles -> `status_out`=0 and `data_out`=0x00; release -> `status_out`=1 within 1 cycle.
- Single word: send bits 1,0,0,0,0,0,0,0, each as a 10-cycle `write_in` high / 10-cycle low with `data_in` stable -> one FIFO entry 0x80, `status_out` stays 1.
- Fill: send words 0x80 through 0x87 -> occupancy 8 and `status_out`=0; 4 further `write_in` pulses change nothing.
- Drain: 4 `dequeue_in` pulses (200 cycles high, 600 low):
  - `data_out` = 0x80, 0x81, 0x82, 0x83 in order.
  - `status_out` returns to 1 after the first dequeue.
- Empty: dequeue with an empty FIFO -> `data_out` unchanged, occupancy stays 0.
- Wrap and simultaneity:
  - Interleave 12 enqueues with dequeues -> FIFO order preserved across the pointer wrap.
  - Dequeue in the same cycle as an auto-enqueue -> occupancy unchanged.
